// File: rtl/median_rank_n_if.sv
// Sample stream interface for median_rank_n: sample strobe in, rank result out.
interface median_rank_n_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 9,
  parameter int unsigned SELW  = $clog2(N)
);
  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic [SELW-1:0]  SEL;
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             BUSY;

  // Producer side: drives samples and rank select, observes results
  modport master (output DI, DSI, SEL, input DO, DSO, BUSY);
  // Filter side: consumes samples, produces the selected-rank result
  modport slave  (input DI, DSI, SEL, output DO, DSO, BUSY);
endinterface

// File: rtl/median_rank_n.sv
// Streaming rank-order filter over windows of N samples.
// Samples are kept in an ascending register array, inserted one per cycle.
// Define MEDIAN_RANK_N_SIGNED_EN for two's-complement sample ordering.
module median_rank_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 9,
  parameter int unsigned SELW  = $clog2(N)
) (
  input logic            CLK,
  input logic            nRST,
  median_rank_n_if.slave bus
);

  localparam int unsigned     CW   = $clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);
  localparam logic [SELW-1:0] RMAX = SELW'(N - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_nxt_cnt;
  logic [SELW-1:0]  r_rank;
  logic [SELW-1:0]  w_nxt_rank;
  logic             w_done;
  logic [N-1:0]     r_val;
  logic [WIDTH-1:0] r_dat [N];
  logic [WIDTH-1:0] r_do;
  logic             r_dso;

  logic [N-1:0]     w_v;
  logic [N-1:0]     w_gt;
  logic [N-1:0]     w_ins_val;
  logic [WIDTH-1:0] w_ins_dat [N];

  // Ordering used for insertion; strict so equal samples land after existing ones
  function automatic logic f_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MEDIAN_RANK_N_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Parallel compare and shift-up: array contents after inserting DI
  always_comb begin
    w_v = (r_cnt == '0) ? '0 : r_val;
    for (int i = 0; i < N; i++) begin
      w_gt[i] = w_v[i] & f_gt(r_dat[i], bus.DI);
    end
    w_ins_val[0] = 1'b1;
    w_ins_dat[0] = (w_gt[0] || !w_v[0]) ? bus.DI : r_dat[0];
    for (int i = 1; i < N; i++) begin
      w_ins_val[i] = w_v[i] | w_v[i-1];
      if (w_gt[i-1]) begin
        w_ins_dat[i] = r_dat[i-1];
      end else if (w_v[i-1] && (w_gt[i] || !w_v[i])) begin
        w_ins_dat[i] = bus.DI;
      end else begin
        w_ins_dat[i] = r_dat[i];
      end
    end
  end

  // Window sequencing: count, rank capture at window start, completion detect
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_rank  = r_rank;
    w_done      = 1'b0;
    if (bus.DSI) begin
      if (r_cnt == LAST) begin
        w_nxt_cnt = '0;
        w_done    = 1'b1;
      end else begin
        w_nxt_cnt = r_cnt + CW'(1);
      end
      case (r_state)
        IDLE: begin
          w_nxt_state = FILL;
          w_nxt_rank  = (bus.SEL > RMAX) ? RMAX : bus.SEL;
        end
        FILL: begin
          if (r_cnt == LAST) w_nxt_state = IDLE;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  // Control registers and registered result
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rank  <= '0;
      r_val   <= '0;
      r_do    <= '0;
      r_dso   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_rank  <= w_nxt_rank;
      r_dso   <= w_done;
      if (bus.DSI) r_val <= w_done ? '0 : w_ins_val;
      if (w_done) r_do <= w_ins_dat[r_rank];
    end
  end

  // Sample storage; contents are qualified by r_val so no reset is needed
  always_ff @(posedge CLK) begin
    if (bus.DSI) r_dat <= w_ins_dat;
  end

  assign bus.DO   = r_do;
  assign bus.DSO  = r_dso;
  assign bus.BUSY = (r_state == FILL);

endmodule

// File: tb/tb_median_rank_n.sv
// Self-checking bench for median_rank_n (N=9, WIDTH=8) with an expected-result queue.
module tb_median_rank_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 9;
  localparam int unsigned SELW  = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] win_a [9];
  logic [WIDTH-1:0] exp_v;

  median_rank_n_if #(.WIDTH(WIDTH), .N(N)) bus ();

  median_rank_n #(.WIDTH(WIDTH), .N(N)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Apply inputs at a falling edge and advance to the next falling edge
  task automatic drive(input logic dsi, input logic [WIDTH-1:0] di, input logic [SELW-1:0] sel);
    bus.DSI = dsi;
    bus.DI  = di;
    bus.SEL = sel;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.DSI = 1'b0;
    bus.DI  = '0;
    bus.SEL = '0;
    rst_n   = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.DO !== 8'd0) $display("FAIL reset_do got=%0d want=0", bus.DO); else n_pass++;
    n_total++;
    if (bus.DSO !== 1'b0) $display("FAIL reset_dso got=%0b want=0", bus.DSO); else n_pass++;
    n_total++;
    if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%0b want=0", bus.BUSY); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_q.push_back(8'd5);
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, WIDTH'(9 - k), SELW'(4));
      n_total++;
      if (bus.BUSY !== (k < 8)) $display("FAIL basic_busy k=%0d got=%0b want=%0b", k, bus.BUSY, (k < 8));
      else n_pass++;
      n_total++;
      if (bus.DSO !== (k == 8)) $display("FAIL basic_dso k=%0d got=%0b want=%0b", k, bus.DSO, (k == 8));
      else n_pass++;
      if (bus.DSO === 1'b1) begin
        n_total++;
        exp_v = exp_q.pop_front();
        if (bus.DO !== exp_v) $display("FAIL basic_do got=%0d want=%0d", bus.DO, exp_v); else n_pass++;
      end
    end
    drive(1'b0, 'x, '0);
    n_total++;
    if (bus.DSO !== 1'b0) $display("FAIL basic_dso_single got=%0b want=0", bus.DSO); else n_pass++;
    n_total++;
    if (bus.DO !== 8'd5) $display("FAIL basic_do_hold got=%0d want=5", bus.DO); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    exp_q.push_back(8'd50);
    for (int k = 0; k < 18; k++) begin
      if (k == 9) exp_q.push_back(8'd200);
      drive(1'b1, (k < 9) ? win_a[k] : WIDTH'(200), SELW'(4));
      if (bus.DSO === 1'b1) begin
        pulses.push_back(k);
        n_total++;
        exp_v = exp_q.pop_front();
        if (bus.DO !== exp_v) $display("FAIL b2b_do k=%0d got=%0d want=%0d", k, bus.DO, exp_v); else n_pass++;
      end
      if (k == 13) begin
        n_total++;
        if (bus.DO !== 8'd50) $display("FAIL b2b_do_hold got=%0d want=50", bus.DO); else n_pass++;
      end
    end
    drive(1'b0, 'x, '0);
    n_total++;
    if (pulses.size() != 2 || pulses[0] != 8 || pulses[1] != 17)
      $display("FAIL b2b_pulse_times got_count=%0d want pulses after samples 9 and 18", pulses.size());
    else n_pass++;
  endtask

  task automatic test_gapped();
    int gap_after [3] = '{1, 4, 6};
    int gap_len   [3] = '{1, 3, 7};
    exp_q.push_back(8'd50);
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, win_a[k], SELW'(4));
      n_total++;
      if (bus.DSO !== (k == 8)) $display("FAIL gap_dso k=%0d got=%0b want=%0b", k, bus.DSO, (k == 8));
      else n_pass++;
      if (bus.DSO === 1'b1) begin
        n_total++;
        exp_v = exp_q.pop_front();
        if (bus.DO !== exp_v) $display("FAIL gap_do got=%0d want=%0d", bus.DO, exp_v); else n_pass++;
      end
      for (int g = 0; g < 3; g++) begin
        if (gap_after[g] == k) begin
          for (int c = 0; c < gap_len[g]; c++) begin
            drive(1'b0, 'x, SELW'($urandom_range(0, 15)));
            n_total++;
            if (bus.BUSY !== 1'b1 || bus.DSO !== 1'b0)
              $display("FAIL gap_hold k=%0d busy=%0b dso=%0b want busy=1 dso=0", k, bus.BUSY, bus.DSO);
            else n_pass++;
          end
        end
      end
    end
    drive(1'b0, 'x, '0);
    n_total++;
    if (bus.DO !== 8'd50) $display("FAIL gap_do_xhold got=%0d want=50", bus.DO); else n_pass++;
  endtask

  task automatic test_rank_select();
    logic [SELW-1:0]  sels [4] = '{4'd0, 4'd8, 4'd12, 4'd4};
    logic [WIDTH-1:0] exps [4] = '{8'd10, 8'd90, 8'd90, 8'd50};
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(exps[s]);
      for (int k = 0; k < 9; k++) begin
        // last case changes SEL to 0 after the first sample
        drive(1'b1, win_a[k], (s == 3 && k > 0) ? SELW'(0) : sels[s]);
      end
      n_total++;
      if (bus.DSO !== 1'b1) begin
        $display("FAIL rank_dso s=%0d got=%0b want=1", s, bus.DSO);
        void'(exp_q.pop_front());
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.DO !== exp_v) $display("FAIL rank_do sel=%0d got=%0d want=%0d", sels[s], bus.DO, exp_v);
        else n_pass++;
      end
    end
    drive(1'b0, 'x, '0);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, WIDTH'(k + 1), SELW'(4));
    bus.DSI = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.DO !== 8'd0 || bus.DSO !== 1'b0 || bus.BUSY !== 1'b0)
      $display("FAIL async_reset do=%0d dso=%0b busy=%0b want 0/0/0", bus.DO, bus.DSO, bus.BUSY);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'd5);
    for (int k = 0; k < 9; k++) drive(1'b1, WIDTH'(k + 1), SELW'(4));
    n_total++;
    if (bus.DSO !== 1'b1) begin
      $display("FAIL reset_window_dso got=%0b want=1", bus.DSO);
      void'(exp_q.pop_front());
    end else begin
      exp_v = exp_q.pop_front();
      if (bus.DO !== exp_v) $display("FAIL reset_window_do got=%0d want=%0d", bus.DO, exp_v); else n_pass++;
    end
    drive(1'b0, 'x, '0);
  endtask

  task automatic test_signedness();
    logic [WIDTH-1:0] vals [9] = '{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hFE, 8'h02, 8'h81, 8'h03};
`ifdef MEDIAN_RANK_N_SIGNED_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'h7F);
`endif
    for (int k = 0; k < 9; k++) drive(1'b1, vals[k], SELW'(4));
    n_total++;
    if (bus.DSO !== 1'b1) begin
      $display("FAIL sign_dso got=%0b want=1", bus.DSO);
      void'(exp_q.pop_front());
    end else begin
      exp_v = exp_q.pop_front();
      if (bus.DO !== exp_v) $display("FAIL sign_do got=%0h want=%0h", bus.DO, exp_v); else n_pass++;
    end
    drive(1'b0, 'x, '0);
  endtask

  initial begin
    win_a = '{8'd70, 8'd10, 8'd90, 8'd30, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_rank_select();
    test_async_reset();
    test_signedness();
    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule

// File: doc/median_rank_n.md
Name: median_rank_n

Overview:
- Streaming rank-order filter; generalised successor of the fixed 9-sample median block.
- Collects a window of N serial samples and outputs the sample of selected rank (min, median, max or any rank between).
- Supports gapped input (DSI may drop mid-window) and back-to-back windows with no dead cycles.
- Sits in the image-processing pipeline between the pixel window fetcher and the output formatter.

Parameters:
- WIDTH, 8, sample width in bits.
- N, 9, window length in samples; odd, 3..31. The default SEL should select the median (N-1)/2.
- SELW, $clog2(N), width of SEL; derived, not to be overridden.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- DI  input  WIDTH  sample data; accepted on a rising CLK edge when DSI=1.
- DSI  input  1  sample strobe; one sample accepted per cycle while high.
- SEL  input  SELW  rank select, 0 = smallest; sampled with the first sample of each window.
- DO  output  WIDTH  selected-rank result; registered, held until the next result.
- DSO  output  1  one-cycle pulse; DO is new in this same cycle.
- BUSY  output  1  high while a window is partially filled (1..N-1 samples held).

Behaviour:
- Reset (nRST=0, asynchronous): DO=0, DSO=0, BUSY=0, sample count=0, stored rank=0, sort array contents invalid.
  - Reset mid-window discards every partial sample.
  - The first accepted sample after reset release starts a fresh window.
- Storage:
  - N-entry sorted register array with a valid bit per entry, kept ascending.
  - Each accepted sample is inserted in one cycle by parallel compare and shift-up, so there is no multi-cycle sort.
  - Equal values insert after existing equal entries (stable).
- Count:
  - 0..N-1; increments on each accepted sample.
  - Wraps to 0 on the edge that accepts the Nth sample.
  - DSI=0 holds count and array unchanged (gap). Gaps of any length are legal.
- Window start (count=0 and DSI=1):
  - The array is treated as empty; all previous entries are ignored.
  - SEL is captured into the stored rank.
  - SEL values >= N are clamped to N-1.
  - SEL is ignored on all other cycles.
- Window completion (count=N-1 and DSI=1):
  - On that edge, DO <= entry[stored rank] of the array including the incoming sample, computed combinationally.
  - DSO <= 1. Latency is 1 cycle from the final sample edge to DSO/DO.
  - The array is marked empty for the next window.
- DSO:
  - High for exactly one cycle per completed window; otherwise 0.
  - If DSI stays high continuously, DSO pulses every N cycles.
- Back-to-back: a sample accepted in the cycle where DSO=1 is the first sample of the next window. No bubble is required.
- BUSY = (count != 0); registered-equivalent, derived from the count register.
- Comparison: unsigned magnitude by default (see Optional Feature).
- Internal FSM states:
  - IDLE: count=0, no window open.
  - FILL: 0<count<N.
  - Transitions: IDLE->FILL on an accepted sample. FILL->IDLE on the Nth sample, or FILL->FILL when that edge also accepts a new window start (effectively IDLE for one edge, merged).
- X on DI while DSI=0 must not propagate into DO.

Optional Feature:
- Macro MEDIAN_RANK_N_SIGNED_EN.
- Defined: DI is two's-complement and all insertion comparisons are signed. DO is the signed rank result.
- Undefined: unsigned comparison. Ports, timing and latency are identical in both builds.

Test Plan:
- N=9, WIDTH=8, SEL=4; DI=9,8,7,6,5,4,3,2,1 on 9 contiguous DSI cycles -> DSO pulses once, 1 cycle after the 9th edge; DO=5; BUSY high for samples 1..8, low with DSO.
- 18 contiguous samples, SEL=4: window A = 70,10,90,30,50,20,80,40,60; window B = nine x 200 -> DO=50 at the first DSO, DO=200 exactly 9 cycles later; no missed sample; DO holds 50 between pulses.
- Gapped input: the same window A with DSI low for 1, 3 and 7 cycles between random samples -> DO=50; DSO occurs only after the 9th accepted sample; count frozen during gaps.
- Rank select on window A: SEL=0 -> DO=10; SEL=8 -> DO=90; SEL=12 -> DO=90 (clamp); SEL changed mid-window from 4 to 0 -> DO=50 (captured at window start).
- Async reset: assert nRST after 5 samples, between edges -> DO=0, DSO=0, BUSY=0 immediately; then a fresh window 1..9 with SEL=4 -> DO=5.
- With MEDIAN_RANK_N_SIGNED_EN: DI=0x80,0x7F,0xFF,0x01,0x00,0xFE,0x02,0x81,0x03, SEL=4 -> DO=0x00. Without the macro, the same stimulus -> DO=0x7F.
